// File: rtl/display_pkg.sv
// Shared display definitions for the message scanner.
//   MSG_LEN   : number of characters in the message buffer
//   RESET_MSG : power-up message, entry i holds character code i (0..F)
//   DIG_AN*   : count1 codes during which each anode is active
//   reset_entry(): returns one character of RESET_MSG
package display_pkg;

    localparam int MSG_LEN = 16;

    // Entry i lives in bits [4*i+3:4*i].
    localparam logic [4*MSG_LEN-1:0] RESET_MSG = 64'hFEDC_BA98_7654_3210;

    localparam logic [3:0] DIG_AN3 = 4'b1110;
    localparam logic [3:0] DIG_AN2 = 4'b1010;
    localparam logic [3:0] DIG_AN1 = 4'b0110;
    localparam logic [3:0] DIG_AN0 = 4'b0010;

    function automatic logic [3:0] reset_entry(input int idx);
        return RESET_MSG[idx*4 +: 4];
    endfunction

endpackage

// File: rtl/message_scanner_tick_gen.sv
// Scan prescaler: counts 0..SCAN_DIV-1 and flags the terminal count.
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   step  : high for one clk cycle when the prescaler is at terminal count
module tick_gen #(
    parameter int SCAN_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    output logic step
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(SCAN_DIV - 1);

    logic [CW-1:0] presc_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_reg <= '0;
        end else if (presc_reg == TERM) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    // Decoded from the counter so the step lands on the SCAN_DIV-th edge
    // after reset release.
    assign step = (presc_reg == TERM);

endmodule

// File: rtl/message_scanner.sv
// Four-digit scrolling message scanner.
// Drives a down-counting scan state (count1) for an anode driver and
// presents the character for the digit that is, or is about to be, lit.
// The message is held in a 16 x 4-bit buffer that can be rewritten at
// run time and scrolls one character every SCROLL_TICKS frames.
//   clk        : system clock
//   reset      : asynchronous, active-low reset
//   scroll_en  : enable scrolling
//   load_valid : write request into the message buffer
//   load_addr  : buffer entry to write
//   load_data  : character code to write
//   load_ready : buffer accepts a write this cycle
//   count1     : scan state, 1111 down to 0000
//   char       : character code for the current/next active digit
//   frame_tick : one-cycle pulse after count1 wraps to 1111
module message_scanner
    import display_pkg::*;
#(
    parameter int SCAN_DIV     = 16,
    parameter int SCROLL_TICKS = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scroll_en,
    input  logic       load_valid,
    input  logic [3:0] load_addr,
    input  logic [3:0] load_data,
    output logic       load_ready,
    output logic [3:0] count1,
    output logic [3:0] char,
    output logic       frame_tick
);

    localparam int FW = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(SCROLL_TICKS - 1);

    logic          step;
    logic [3:0]    count1_reg, count1_next;
    logic [3:0]    ptr_reg, ptr_next;
    logic [FW-1:0] fcnt_reg, fcnt_next;
    logic [3:0]    char_reg;
    logic          frame_tick_reg;
    logic          wrap;
    logic          latch_hit;
    logic [1:0]    slot;
    logic [3:0]    rd_addr;
    logic [3:0]    msg_reg [MSG_LEN];
    logic [MSG_LEN-1:0] we;

    tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .step  (step)
    );

    assign wrap        = step && (count1_reg == 4'b0000);
    assign count1_next = step ? (count1_reg - 4'd1) : count1_reg;

    // Scroll pointer only moves on a frame wrap, so every digit of a frame
    // is read with the same pointer.
    always_comb begin
        ptr_next  = ptr_reg;
        fcnt_next = fcnt_reg;
        if (!scroll_en) begin
            fcnt_next = '0;
        end else if (wrap) begin
            if (fcnt_reg == FRAME_LAST) begin
                fcnt_next = '0;
                ptr_next  = ptr_reg + 4'd1;
            end else begin
                fcnt_next = fcnt_reg + 1'b1;
            end
        end
    end

    // The blank state just before each active digit is active code + 1;
    // the character is fetched on the step that enters it.
    always_comb begin
        latch_hit = 1'b0;
        slot      = 2'd0;
        if (step) begin
            case (count1_next)
                DIG_AN3 + 4'd1: begin latch_hit = 1'b1; slot = 2'd0; end
                DIG_AN2 + 4'd1: begin latch_hit = 1'b1; slot = 2'd1; end
                DIG_AN1 + 4'd1: begin latch_hit = 1'b1; slot = 2'd2; end
                DIG_AN0 + 4'd1: begin latch_hit = 1'b1; slot = 2'd3; end
                default:        begin latch_hit = 1'b0; slot = 2'd0; end
            endcase
        end
    end

    // ptr_next is used so the first latch of a frame already sees the
    // pointer that takes effect at the wrap.
    assign rd_addr = ptr_next + {2'b00, slot};

    // Writes are refused in latch cycles, so the buffer never sees a read
    // and a write in the same cycle.
    assign load_ready = ~latch_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count1_reg     <= 4'b1111;
            ptr_reg        <= 4'd0;
            fcnt_reg       <= '0;
            char_reg       <= reset_entry(0);
            frame_tick_reg <= 1'b0;
        end else begin
            count1_reg     <= count1_next;
            ptr_reg        <= ptr_next;
            fcnt_reg       <= fcnt_next;
            frame_tick_reg <= wrap;
            if (latch_hit) begin
                char_reg <= msg_reg[rd_addr];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MSG_LEN; gi++) begin : g_we
            assign we[gi] = load_valid && load_ready && (load_addr == 4'(gi));
        end
    endgenerate

    // Buffer is register-based: it must come out of reset holding RESET_MSG.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_reg[i] <= reset_entry(i);
            end
        end else begin
            for (int i = 0; i < MSG_LEN; i++) begin
                if (we[i]) begin
                    msg_reg[i] <= load_data;
                end
            end
        end
    end

    assign count1     = count1_reg;
    assign char       = char_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_message_scanner.sv
// Directed bench for message_scanner with SCAN_DIV=2, SCROLL_TICKS=2.
module tb_message_scanner;

    logic       clk;
    logic       reset;
    logic       scroll_en;
    logic       load_valid;
    logic [3:0] load_addr;
    logic [3:0] load_data;
    logic       load_ready;
    logic [3:0] count1;
    logic [3:0] char;
    logic       frame_tick;

    int n_checks = 0;
    int n_pass   = 0;

    message_scanner #(
        .SCAN_DIV     (2),
        .SCROLL_TICKS (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .scroll_en  (scroll_en),
        .load_valid (load_valid),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_ready (load_ready),
        .count1     (count1),
        .char       (char),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance at least one cycle, then stop on the first cycle where
    // count1 equals s (bounded).
    task automatic wait_state(input logic [3:0] s);
        int n;
        n = 0;
        do begin
            next_cycle();
            n++;
        end while (count1 !== s && n < 100);
        check($sformatf("reach count1=%0h", s), {28'd0, count1}, {28'd0, s});
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            next_cycle();
            n++;
        end while (frame_tick !== 1'b1 && n < 200);
        check("frame_tick pulse", {31'd0, frame_tick}, 32'd1);
    endtask

    // Check the four digits of one frame, in scan order an3..an0.
    task automatic check_frame(input string tag, input logic [3:0] c3, input logic [3:0] c2,
                               input logic [3:0] c1, input logic [3:0] c0);
        wait_state(4'b1110);
        check({tag, " an3"}, {28'd0, char}, {28'd0, c3});
        wait_state(4'b1010);
        check({tag, " an2"}, {28'd0, char}, {28'd0, c2});
        wait_state(4'b0110);
        check({tag, " an1"}, {28'd0, char}, {28'd0, c1});
        wait_state(4'b0010);
        check({tag, " an0"}, {28'd0, char}, {28'd0, c0});
    endtask

    initial begin
        int ft_count;

        reset      = 1'b0;
        scroll_en  = 1'b0;
        load_valid = 1'b0;
        load_addr  = 4'd0;
        load_data  = 4'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset count1", {28'd0, count1}, 32'hF);
        check("reset char", {28'd0, char}, 32'h0);
        check("reset frame_tick", {31'd0, frame_tick}, 32'd0);
        check("reset load_ready", {31'd0, load_ready}, 32'd1);

        // Release and time the first frame
        reset = 1'b1;
        ft_count = 0;
        for (int i = 1; i <= 34; i++) begin
            next_cycle();
            if (frame_tick === 1'b1) ft_count++;
            if (i == 1) begin
                check("count1 after 1 clk", {28'd0, count1}, 32'hF);
                check("char after release", {28'd0, char}, 32'h0);
            end
            if (i == 2) check("count1 after 2 clk", {28'd0, count1}, 32'hE);
            if (i == 32) begin
                check("count1 after 32 clk", {28'd0, count1}, 32'hF);
                check("frame_tick at wrap", {31'd0, frame_tick}, 32'd1);
            end
        end
        check("frame_tick pulse count", ft_count, 1);
        $display("frame timing done, ft_count=%0d", ft_count);

        // Static message, two frames
        for (int f = 0; f < 2; f++) begin
            check_frame($sformatf("static f%0d", f), 4'h0, 4'h1, 4'h2, 4'h3);
        end

        // Scrolling
        wait_frame();
        scroll_en = 1'b1;
        wait_frame();
        wait_frame();
        check_frame("scroll ptr=1", 4'h1, 4'h2, 4'h3, 4'h4);
        for (int f = 0; f < 26; f++) wait_frame();
        check_frame("scroll ptr=14", 4'hE, 4'hF, 4'h0, 4'h1);
        for (int f = 0; f < 4; f++) wait_frame();
        check_frame("scroll ptr=0", 4'h0, 4'h1, 4'h2, 4'h3);
        scroll_en = 1'b0;

        // Mid-frame write: msg[2] = 9, shown at an1 next frame
        wait_state(4'b0101);
        check("ready mid-frame", {31'd0, load_ready}, 32'd1);
        load_valid = 1'b1;
        load_addr  = 4'd2;
        load_data  = 4'd9;
        next_cycle();
        load_valid = 1'b0;
        $display("write addr=2 data=9");
        wait_state(4'b0110);
        check("an1 after write", {28'd0, char}, 32'h9);

        // Request held across a latch cycle
        wait_state(4'b1100);
        check("ready before latch", {31'd0, load_ready}, 32'd1);
        next_cycle();
        check("ready in latch cycle", {31'd0, load_ready}, 32'd0);
        load_valid = 1'b1;
        load_addr  = 4'd3;
        load_data  = 4'd7;
        next_cycle();
        check("count1 after latch", {28'd0, count1}, 32'hB);
        check("ready after latch", {31'd0, load_ready}, 32'd1);
        next_cycle();
        load_valid = 1'b0;
        $display("write addr=3 data=7 (held over latch)");
        wait_state(4'b0010);
        check("an0 after held write", {28'd0, char}, 32'h7);

        // Move ptr to 1, then reset mid-frame
        wait_frame();
        scroll_en = 1'b1;
        wait_frame();
        wait_frame();
        scroll_en = 1'b0;
        wait_state(4'b1010);
        check("ptr=1 an2 shows msg[2]", {28'd0, char}, 32'h9);
        wait_state(4'b0110);
        reset      = 1'b0;
        load_valid = 1'b1;
        load_addr  = 4'd2;
        load_data  = 4'd5;
        #1;
        check("async reset count1", {28'd0, count1}, 32'hF);
        check("async reset char", {28'd0, char}, 32'h0);
        check("async reset frame_tick", {31'd0, frame_tick}, 32'd0);
        check("async reset load_ready", {31'd0, load_ready}, 32'd1);
        next_cycle();
        check("held reset count1", {28'd0, count1}, 32'hF);
        reset      = 1'b1;
        load_valid = 1'b0;
        $display("reset released after mid-frame reset");
        check_frame("after reset", 4'h0, 4'h1, 4'h2, 4'h3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/message_scanner.md
MESSAGE_SCANNER -- requirements
Module: message_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 16: clk cycles per scan step, >=2.
REQ-002 Parameter SCROLL_TICKS, default 64: frames per one-character scroll step, >=1.
REQ-003 clk  in  1  single system clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 scroll_en  in  1  high: message advances one character every SCROLL_TICKS frames.
REQ-006 load_valid  in  1  write request into the message buffer.
REQ-007 load_addr  in  4  buffer entry to write, 0..15.
REQ-008 load_data  in  4  hex character code to write.
REQ-009 load_ready  out  1  buffer accepts a write this cycle.
REQ-010 count1  out  4  down-counting scan state that drives the anode driver.
REQ-011 char  out  4  character code for the digit whose anode is or will next be active.
REQ-012 frame_tick  out  1  one-clk pulse at each count1 wrap from 0000 to 1111.

Function
REQ-013 An internal prescaler SHALL count 0..SCAN_DIV-1 and SHALL assert a one-cycle step at terminal count.
REQ-014 count1 SHALL decrement by 1 on each step and SHALL wrap from 0000 to 1111; 16 steps SHALL form one frame.
REQ-015 frame_tick SHALL be high exactly in the cycle after the step that wraps count1 to 1111.
REQ-016 Digit mapping: an3 is active at count1=1110, an2 at 1010, an1 at 0110, an0 at 0010; all other states are blank.
REQ-017 char SHALL latch on the step that enters count1 = 1111, 1011, 0111 or 0011 (blank states).
REQ-018 The latched value SHALL be msg[(ptr+k) mod 16], with k = 0, 1, 2, 3 for count1[3:2] = 11, 10, 01, 00.
REQ-019 char SHALL remain stable from its latch step through the following active state.
REQ-020 A 4-bit scroll pointer ptr SHALL change only on a frame wrap, so a frame never shows mixed pointer values.
REQ-021 With scroll_en high, a frame counter SHALL count wraps.
REQ-022 When the frame counter reaches SCROLL_TICKS-1, ptr SHALL increment mod 16 (15 to 0) and the frame counter SHALL clear.
REQ-023 With scroll_en low, ptr SHALL hold and the frame counter SHALL clear.
REQ-024 The message buffer SHALL hold 16 entries of 4 bits; load_valid && load_ready SHALL write load_data to msg[load_addr] at that edge.
REQ-025 load_ready SHALL be low only in a cycle in which a char latch step occurs, and high in all other cycles.
REQ-026 A write request made while load_ready is low SHALL not be taken; the master SHALL hold the request, and it SHALL be taken in the next cycle.
REQ-027 A written entry SHALL be visible at the next latch of that entry; there SHALL be no same-cycle read/write bypass.

Reset
REQ-028 Asserting reset SHALL, asynchronously: prescaler=0, count1=1111, ptr=0, frame counter=0, frame_tick=0, load_ready=1, msg[i]=RESET_MSG[i], char=RESET_MSG[0].
REQ-029 Reset asserted mid-frame SHALL override all activity, including a pending write.
REQ-030 The first step after reset release SHALL occur SCAN_DIV cycles after the first active clk edge.

Structure
REQ-031 A shared package display_pkg SHALL hold MSG_LEN=16, RESET_MSG (entry i = i, i.e. 0..F), and the four active digit state codes.
REQ-032 The prescaler SHALL be the sub-module tick_gen (parameter SCAN_DIV; outputs step); all other logic SHALL reside in message_scanner.

Verification (SCAN_DIV=2, SCROLL_TICKS=2)
REQ-033 Release reset -> count1=1111 and char=0; count1=1110 after 2 clk; back to 1111 after 32 clk, with frame_tick high for exactly 1 clk.
REQ-034 scroll_en=0 -> char = 0, 1, 2, 3 during count1 = 1110, 1010, 0110, 0010, repeated every frame.
REQ-035 scroll_en=1 -> after 2 frames digits show 1, 2, 3, 4; at ptr=14, E, F, 0, 1; after 32 frames 0, 1, 2, 3.
REQ-036 Write addr 2 = 9 mid-frame -> next frame an1 state shows char=9; load_valid held during a latch cycle -> load_ready=0, write taken next cycle.
REQ-037 Assert reset at count1=0110 -> count1=1111, char=0, ptr=0 immediately, and msg[2] restored to 2.
